// File: rtl/pedal_mem_pkg.sv
// Shared definitions for the pedal's SPI SRAM record/playback paths.
// Holds the opcodes, the frame geometry and the common reader/writer state enum.
package pedal_mem_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam int         ADDR_W     = 24;
    localparam int         SAMPLE_W   = 16;
    localparam int         FRAME_BITS = 8 + ADDR_W + SAMPLE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_DESELECT,
        ST_PRESENT
    } mem_state_t;

endpackage

// File: rtl/spi_sck_div.sv
// Half-period tick generator for the SPI clock.
// Ticks alternate rise/fall, starting with a rise, and restart whenever disabled.
module spi_sck_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             phase;
    logic             tick;

    assign tick      = en && (cnt == CNT_W'(CLK_DIV - 1));
    assign rise_tick = tick && !phase;
    assign fall_tick = tick && phase;

    // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= !phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_loop_reader.sv
// Loop playback reader: one standalone SPI READ frame per 16-bit sample,
// presented on a single-buffered valid/ready stream, address wrapping inside latched bounds.
module spi_loop_reader #(
    parameter int         SAMPLE_W = pedal_mem_pkg::SAMPLE_W,
    parameter int         ADDR_W   = pedal_mem_pkg::ADDR_W,
    parameter int         CLK_DIV  = 2,
    parameter logic [7:0] CMD_READ = pedal_mem_pkg::CMD_READ
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [ADDR_W-1:0]   loop_start_addr,
    input  logic [ADDR_W-1:0]   loop_end_addr,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                wrap,
    output logic                busy,
    output logic                spi_cs_n,
    output logic                spi_sck,
    output logic                spi_mosi,
    input  logic                spi_miso
);

    import pedal_mem_pkg::*;

    localparam int FRAME_W = 8 + ADDR_W + SAMPLE_W;
    localparam int BIT_W   = $clog2(FRAME_W + 1);
    localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    mem_state_t          state, state_next;
    logic [ADDR_W-1:0]   start_l, end_l, addr;
    logic [ADDR_W-1:0]   start_even, end_even, next_addr, frame_addr;
    logic [FRAME_W-2:0]  tx;
    logic [SAMPLE_W-1:0] rx;
    logic [BIT_W-1:0]    fall_cnt;
    logic [CNT_W-1:0]    ds_cnt;
    logic                stop_req;
    logic                rise_tick, fall_tick, div_en;
    logic                launch, handshake, stopping, load_frame;
    logic                shift_done, sck_rise, sck_fall, hold_done, ds_done;

    assign start_even = loop_start_addr & ~ADDR_W'(1);
    assign end_even   = loop_end_addr & ~ADDR_W'(1);
    assign next_addr  = (addr == end_l) ? start_l : addr + ADDR_W'(2);
    assign frame_addr = launch ? start_even : next_addr;

    assign launch     = (state == ST_IDLE) && start && !stop;
    assign handshake  = (state == ST_PRESENT) && sample_valid && sample_ready;
    assign stopping   = stop || stop_req;
    assign load_frame = launch || (handshake && !stopping);

    // The tick after the 48th falling edge closes the last low half-period.
    assign shift_done = (state == ST_SHIFT) && rise_tick && (fall_cnt == BIT_W'(FRAME_W));
    assign sck_rise   = rise_tick && ((state == ST_CS_SETUP) || ((state == ST_SHIFT) && !shift_done));
    assign sck_fall   = fall_tick && (state == ST_SHIFT);
    assign hold_done  = (state == ST_CS_HOLD) && (rise_tick || fall_tick);
    assign ds_done    = ds_cnt == CNT_W'(CLK_DIV - 1);

    assign div_en = (state == ST_CS_SETUP) || (state == ST_SHIFT) || (state == ST_CS_HOLD);
    assign busy   = (state != ST_IDLE);

    spi_sck_div #(.CLK_DIV(CLK_DIV)) u_sck_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (div_en),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next is defaulted before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (launch)     state_next = ST_CS_SETUP;
            ST_CS_SETUP: if (rise_tick)  state_next = ST_SHIFT;
            ST_SHIFT:    if (shift_done) state_next = ST_CS_HOLD;
            ST_CS_HOLD:  if (hold_done)  state_next = ST_DESELECT;
            ST_DESELECT: if (ds_done)    state_next = ST_PRESENT;
            ST_PRESENT:  if (handshake)  state_next = stopping ? ST_IDLE : ST_CS_SETUP;
            default:                     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_l      <= '0;
            end_l        <= '0;
            addr         <= '0;
            tx           <= '0;
            rx           <= '0;
            fall_cnt     <= '0;
            ds_cnt       <= '0;
            stop_req     <= 1'b0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
            spi_cs_n     <= 1'b1;
            spi_sck      <= 1'b0;
            spi_mosi     <= 1'b0;
        end else begin
            wrap   <= 1'b0;
            ds_cnt <= (state == ST_DESELECT) ? ds_cnt + 1'b1 : '0;

            if (state == ST_IDLE) stop_req <= 1'b0;
            else if (stop)        stop_req <= 1'b1;

            if (launch) begin
                start_l <= start_even;
                end_l   <= end_even;
                addr    <= start_even;
            end

            if (load_frame) begin
                tx       <= {CMD_READ[6:0], frame_addr, {SAMPLE_W{1'b0}}};
                spi_mosi <= CMD_READ[7];
                spi_cs_n <= 1'b0;
                fall_cnt <= '0;
            end

            if (sck_rise) begin
                spi_sck <= 1'b1;
                rx      <= {rx[SAMPLE_W-2:0], spi_miso};
            end

            // Data bits shift out as zeros behind the address.
            if (sck_fall) begin
                spi_sck  <= 1'b0;
                fall_cnt <= fall_cnt + 1'b1;
                spi_mosi <= tx[FRAME_W-2];
                tx       <= {tx[FRAME_W-3:0], 1'b0};
            end

            if (hold_done) begin
                spi_cs_n    <= 1'b1;
                sample_data <= rx;
            end

            if ((state == ST_DESELECT) && ds_done) sample_valid <= 1'b1;

            if (handshake) begin
                sample_valid <= 1'b0;
                addr         <= next_addr;
                wrap         <= (addr == end_l);
            end
        end
    end

endmodule
